// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle fetch/decode/control FSM.
// Owns PC, IR and data-address register; drives datapath controls.
module cpu_controller #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  input  logic [15:0] datapath_out,
  output logic [1:0]  mem_cmd,
  output logic [7:0]  mem_addr,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [7:0]  PC,
  output logic        halted
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD, S_DEC,
    S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG,
    S_ADDR, S_LADDR, S_MRD1, S_MRD2,
    S_GETBD, S_MOVC, S_MWR, S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  pc_q;
  logic [15:0] ir;
  logic [7:0]  addr;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;

  logic is_movi, is_movr, is_ab;
  logic is_cmp, is_mvn, is_ldr, is_str;

  // Upper datapath bits never address memory.
  logic unused_dp;
  assign unused_dp = ^datapath_out[15:8];

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_ab   = (opcode == 3'b101) && !op[0];
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign PC     = pc_q;

  // State, PC, IR and data-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      pc_q  <= RESET_PC;
      ir    <= 16'h0000;
      addr  <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == S_IF2)   ir   <= read_data;
      if (state == S_UPD)   pc_q <= pc_q + 8'd1;
      if (state == S_LADDR) addr <= datapath_out[7:0];
    end
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:   state_nx = S_IF1;
      S_IF1:   state_nx = S_IF2;
      S_IF2:   state_nx = S_UPD;
      S_UPD:   state_nx = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          is_movi:                   state_nx = S_WIMM;
          is_movr | is_mvn:          state_nx = S_GETB;
          is_ab | is_cmp:            state_nx = S_GETA;
          is_ldr | is_str:           state_nx = S_GETA;
          default:                   state_nx = S_HALT;
        endcase
      end
      S_WIMM:  state_nx = S_IF1;
      S_GETA:  state_nx = (is_ldr || is_str) ? S_ADDR : S_GETB;
      S_GETB:  state_nx = S_EXEC;
      S_EXEC:  state_nx = is_cmp ? S_IF1 : S_WREG;
      S_WREG:  state_nx = S_IF1;
      S_ADDR:  state_nx = S_LADDR;
      S_LADDR: state_nx = is_ldr ? S_MRD1 : S_GETBD;
      S_MRD1:  state_nx = S_MRD2;
      S_MRD2:  state_nx = S_IF1;
      S_GETBD: state_nx = S_MOVC;
      S_MOVC:  state_nx = S_MWR;
      S_MWR:   state_nx = S_IF1;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  // Moore output decode of state plus IR fields.
  always_comb begin
    mem_cmd  = MEM_NONE;
    mem_addr = addr;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 4'b0000;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    shift    = ir[4:3];
    ALUop    = ir[12:11];
    halted   = 1'b0;
    unique case (state)
      S_IF1, S_IF2: begin
        mem_cmd  = MEM_READ;
        mem_addr = pc_q;
      end
      S_WIMM: begin
        vsel     = 4'b0100;
        writenum = rn;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        asel  = is_movr | is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WREG: begin
        vsel     = 4'b0001;
        writenum = rd;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        ALUop = 2'b00;
        loadc = 1'b1;
      end
      S_MRD1: mem_cmd = MEM_READ;
      S_MRD2: begin
        mem_cmd  = MEM_READ;
        vsel     = 4'b1000;
        writenum = rd;
        write    = 1'b1;
      end
      S_GETBD: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      S_MOVC: begin
        asel  = 1'b1;
        shift = 2'b00;
        ALUop = 2'b00;
        loadc = 1'b1;
      end
      S_MWR:  mem_cmd = MEM_WRITE;
      S_HALT: halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench for the fetch/decode controller.
// Memory is a combinational array indexed by mem_addr.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] read_data;
  logic [15:0] datapath_out;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic        loada, loadb, loadc, loads, asel, bsel, write;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic [7:0]  PC;
  logic        halted;

  logic [15:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .read_data(read_data),
    .datapath_out(datapath_out), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .readnum(readnum), .writenum(writenum),
    .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .write(write),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8),
    .sximm5(sximm5), .PC(PC), .halted(halted)
  );

  always #5 clk = ~clk;

  assign read_data = mem[mem_addr];

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  // Leaves the bench at a negedge with the DUT in IF1 (cycle 1).
  task automatic restart;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    fill(16'hE000);
    datapath_out = 16'h0000;
    reset = 1'b1;
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b00) begin fails++; $display("FAIL rst_cmd got %b want 00", mem_cmd); end
    tests++; if (PC !== 8'h00) begin fails++; $display("FAIL rst_pc got %h want 00", PC); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got %b want 0", halted); end
    tests++; if (vsel !== 4'b0000) begin fails++; $display("FAIL rst_vsel got %b want 0000", vsel); end
    tests++; if (sximm8 !== 16'h0000) begin fails++; $display("FAIL rst_sximm8 got %h want 0000", sximm8); end
    tests++; if ({write, loada, loadb, loadc, loads} !== 5'b0) begin fails++; $display("FAIL rst_ctl got %b want 00000", {write, loada, loadb, loadc, loads}); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b00) begin fails++; $display("FAIL rst2_cmd got %b want 00", mem_cmd); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01) begin fails++; $display("FAIL if1_cmd got %b want 01", mem_cmd); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL if1_addr got %h want 00", mem_addr); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01) begin fails++; $display("FAIL if2_cmd got %b want 01", mem_cmd); end
  endtask

  task automatic test_mov_imm;
    int wcnt;
    fill(16'hE000);
    mem[0] = 16'hD005;
    mem[1] = 16'hD1FF;
    restart();
    wcnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      if (write) wcnt++;
    end
    tests++; if (write !== 1'b1) begin fails++; $display("FAIL movi_write got %b want 1", write); end
    tests++; if (wcnt != 1) begin fails++; $display("FAIL movi_wcnt got %0d want 1", wcnt); end
    tests++; if (writenum !== 3'd0) begin fails++; $display("FAIL movi_wnum got %0d want 0", writenum); end
    tests++; if (vsel !== 4'b0100) begin fails++; $display("FAIL movi_vsel got %b want 0100", vsel); end
    tests++; if (sximm8 !== 16'h0005) begin fails++; $display("FAIL movi_imm got %h want 0005", sximm8); end
    @(negedge clk);
    tests++; if (mem_addr !== 8'h01 || mem_cmd !== 2'b01) begin fails++; $display("FAIL movi_if1 got %h/%b want 01/01", mem_addr, mem_cmd); end
    repeat (4) @(negedge clk);
    tests++; if (sximm8 !== 16'hFFFF) begin fails++; $display("FAIL movi2_imm got %h want FFFF", sximm8); end
    tests++; if (write !== 1'b1 || writenum !== 3'd1) begin fails++; $display("FAIL movi2_w got %b/%0d want 1/1", write, writenum); end
    @(negedge clk);
    tests++; if (PC !== 8'h02) begin fails++; $display("FAIL movi2_pc got %h want 02", PC); end
  endtask

  task automatic test_add;
    int wcnt;
    fill(16'hE000);
    mem[0] = 16'hA148;
    restart();
    wcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (write) wcnt++;
      if (c == 5) begin
        tests++; if (readnum !== 3'd1 || loada !== 1'b1) begin fails++; $display("FAIL add_geta got %0d/%b want 1/1", readnum, loada); end
      end
      if (c == 6) begin
        tests++; if (readnum !== 3'd0 || loadb !== 1'b1) begin fails++; $display("FAIL add_getb got %0d/%b want 0/1", readnum, loadb); end
      end
      if (c == 7) begin
        tests++; if ({shift, ALUop, loadc, asel, bsel} !== 7'b01_00_1_0_0) begin fails++; $display("FAIL add_exec got %b want 0100100", {shift, ALUop, loadc, asel, bsel}); end
      end
      if (c == 8) begin
        tests++; if ({write, writenum, vsel} !== 8'b1_010_0001) begin fails++; $display("FAIL add_wreg got %b want 10100001", {write, writenum, vsel}); end
      end
    end
    tests++; if (wcnt != 1) begin fails++; $display("FAIL add_wcnt got %0d want 1", wcnt); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01 || mem_addr !== 8'h01) begin fails++; $display("FAIL add_next got %b/%h want 01/01", mem_cmd, mem_addr); end
  endtask

  task automatic test_cmp;
    int scnt, wcnt;
    fill(16'hE000);
    mem[0] = 16'hA801;
    restart();
    scnt = 0;
    wcnt = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (loads) scnt++;
      if (write) wcnt++;
    end
    tests++; if (ALUop !== 2'b01 || loadc !== 1'b0) begin fails++; $display("FAIL cmp_exec got %b/%b want 01/0", ALUop, loadc); end
    tests++; if (scnt != 1) begin fails++; $display("FAIL cmp_loads got %0d want 1", scnt); end
    tests++; if (wcnt != 0) begin fails++; $display("FAIL cmp_write got %0d want 0", wcnt); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01 || mem_addr !== 8'h01) begin fails++; $display("FAIL cmp_next got %b/%h want 01/01", mem_cmd, mem_addr); end
  endtask

  task automatic test_ldr;
    fill(16'hE000);
    mem[0] = 16'h6062;
    datapath_out = 16'h0007;
    restart();
    repeat (2) @(negedge clk);
    tests++; if (sximm5 !== 16'h0002) begin fails++; $display("FAIL ldr_imm5 got %h want 0002", sximm5); end
    repeat (3) @(negedge clk);
    tests++; if ({bsel, asel, ALUop, loadc} !== 5'b1_0_00_1) begin fails++; $display("FAIL ldr_addr got %b want 10001", {bsel, asel, ALUop, loadc}); end
    repeat (2) @(negedge clk);
    tests++; if (mem_addr !== 8'h07 || mem_cmd !== 2'b01 || write !== 1'b0) begin fails++; $display("FAIL ldr_mrd1 got %h/%b/%b want 07/01/0", mem_addr, mem_cmd, write); end
    @(negedge clk);
    tests++; if (mem_addr !== 8'h07 || mem_cmd !== 2'b01) begin fails++; $display("FAIL ldr_mrd2 got %h/%b want 07/01", mem_addr, mem_cmd); end
    tests++; if ({write, vsel, writenum} !== 8'b1_1000_011) begin fails++; $display("FAIL ldr_wr got %b want 11000011", {write, vsel, writenum}); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01 || mem_addr !== 8'h01) begin fails++; $display("FAIL ldr_next got %b/%h want 01/01", mem_cmd, mem_addr); end
  endtask

  task automatic test_str;
    int wrc;
    fill(16'hE000);
    mem[0] = 16'h807F;
    datapath_out = 16'h0007;
    restart();
    wrc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_cmd == 2'b10) wrc++;
      if (c == 3) begin
        tests++; if (sximm5 !== 16'hFFFF) begin fails++; $display("FAIL str_imm5 got %h want FFFF", sximm5); end
      end
      if (c == 8) begin
        tests++; if (readnum !== 3'd3 || loadb !== 1'b1) begin fails++; $display("FAIL str_getbd got %0d/%b want 3/1", readnum, loadb); end
      end
      if (c == 9) begin
        tests++; if ({asel, bsel, shift, ALUop, loadc} !== 7'b1_0_00_00_1) begin fails++; $display("FAIL str_movc got %b want 1000001", {asel, bsel, shift, ALUop, loadc}); end
      end
      if (c == 10) begin
        tests++; if (mem_cmd !== 2'b10 || mem_addr !== 8'h07) begin fails++; $display("FAIL str_mwr got %b/%h want 10/07", mem_cmd, mem_addr); end
      end
    end
    tests++; if (wrc != 1) begin fails++; $display("FAIL str_wcnt got %0d want 1", wrc); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01 || mem_addr !== 8'h01) begin fails++; $display("FAIL str_next got %b/%h want 01/01", mem_cmd, mem_addr); end
  endtask

  task automatic test_reset_movc;
    fill(16'hE000);
    mem[0] = 16'h807F;
    datapath_out = 16'h0007;
    restart();
    repeat (8) @(negedge clk);
    reset = 1'b1;
    tests++; if (loadc !== 1'b1 || asel !== 1'b1) begin fails++; $display("FAIL rmovc_hold got %b/%b want 1/1", loadc, asel); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b00 || PC !== 8'h00 || loadc !== 1'b0) begin fails++; $display("FAIL rmovc_rst got %b/%h/%b want 00/00/0", mem_cmd, PC, loadc); end
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b00) begin fails++; $display("FAIL rmovc_rst2 got %b want 00", mem_cmd); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (mem_cmd !== 2'b01 || mem_addr !== 8'h00) begin fails++; $display("FAIL rmovc_if1 got %b/%h want 01/00", mem_cmd, mem_addr); end
  endtask

  task automatic test_halt(input logic [15:0] instr);
    int bad;
    fill(16'hE000);
    mem[0] = instr;
    restart();
    repeat (4) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 22; c++) begin
      if (halted !== 1'b1 || mem_cmd !== 2'b00 || PC !== 8'h01) bad++;
      @(negedge clk);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL halt_%h bad cycles %0d want 0", instr, bad); end
  endtask

  task automatic test_pc_wrap;
    fill(16'hD000);
    restart();
    repeat (255 * 5) @(negedge clk);
    tests++; if (PC !== 8'hFF || mem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_ff got %h/%h want FF/FF", PC, mem_addr); end
    repeat (3) @(negedge clk);
    tests++; if (PC !== 8'h00) begin fails++; $display("FAIL wrap_00 got %h want 00", PC); end
  endtask

  initial begin
    reset = 1'b1;
    datapath_out = 16'h0000;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_ldr();
    test_str();
    test_reset_movc();
    test_halt(16'hE000);
    test_halt(16'h0000);
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
